// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock through four shared
// S-boxes. The complete schedule is held on expandedKey, byte-reversed per
// round key, and flagged by key_valid until the next accepted start.
module aes_key_expand_seq #(
  parameter int NR_AES = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [127:0]                key,
  output logic                        busy,
  output logic                        done,
  output logic                        key_valid,
  output logic [128*(NR_AES+1)-1:0]   expandedKey
);

  localparam int              CNT_W = $clog2(NR_AES + 2);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NR_AES);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         w_accept;
  logic                         w_last;
  logic [CNT_W-1:0]             r_cnt;
  logic [7:0]                   r_rcon;
  logic [127:0]                 r_rk;
  logic [128*(NR_AES+1)-1:0]    r_xkey;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_kv;
  logic [31:0]                  w_rot;
  logic [31:0]                  w_t;
  logic [31:0]                  w_w0, w_w1, w_w2, w_w3;
  logic [127:0]                 w_rk_nxt;

  // Byte order swap between FIPS order and the bus layout (byte j at [8j+7:8j]).
  function automatic logic [127:0] byte_rev(input logic [127:0] x);
    logic [127:0] y;
    for (int j = 0; j < 16; j++) y[8*j +: 8] = x[127-8*j -: 8];
    return y;
  endfunction

  // Multiply-by-x in GF(2^8); advances Rcon.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: accept start only in IDLE, return after the last round write.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One key-schedule round; r_rk holds the previous round key in FIPS order (w0 at [127:96]).
  always_comb begin
    w_rot    = {r_rk[23:0], r_rk[31:24]};
    w_t      = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]], SBOX[w_rot[15:8]], SBOX[w_rot[7:0]]}
               ^ {r_rcon, 24'h0};
    w_w0     = r_rk[127:96] ^ w_t;
    w_w1     = r_rk[95:64]  ^ w_w0;
    w_w2     = r_rk[63:32]  ^ w_w1;
    w_w3     = r_rk[31:0]   ^ w_w2;
    w_rk_nxt = {w_w0, w_w1, w_w2, w_w3};
  end

  // Schedule storage, round counter, Rcon and handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_rcon <= 8'h01;
      r_rk   <= '0;
      r_xkey <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_kv   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_rk           <= key;
        r_xkey[127:0]  <= byte_rev(key);
        r_cnt          <= CNT_W'(1);
        r_rcon         <= 8'h01;
        r_busy         <= 1'b1;
        r_kv           <= 1'b0;
      end else if (r_state == S_EXPAND) begin
        r_rk                    <= w_rk_nxt;
        r_xkey[128*r_cnt +: 128] <= byte_rev(w_rk_nxt);
        r_cnt                   <= r_cnt + CNT_W'(1);
        r_rcon                  <= xtime(r_rcon);
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_kv   <= 1'b1;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign key_valid   = r_kv;
  assign expandedKey = r_xkey;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq: FIPS-197 schedule, handshake timing,
// start-while-busy, back-to-back restart and asynchronous reset mid-run.
module tb_aes_key_expand_seq;

  localparam int NR = 10;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [127:0]           key;
  logic                   busy;
  logic                   done;
  logic                   key_valid;
  logic [128*(NR+1)-1:0]  expandedKey;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;

  // FIPS-197 Appendix A.1 round keys for 2b7e151628aed2a6abf7158809cf4f3c, FIPS order.
  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_expand_seq #(.NR_AES(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key         (key),
    .busy        (busy),
    .done        (done),
    .key_valid   (key_valid),
    .expandedKey (expandedKey)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] y;
    for (int j = 0; j < 16; j++) y[8*j +: 8] = x[127-8*j -: 8];
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d, input logic v);
    check({tag, "_busy"}, 128'(busy), 128'(b));
    check({tag, "_done"}, 128'(done), 128'(d));
    check({tag, "_kv"},   128'(key_valid), 128'(v));
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    key   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= NR; i++) check($sformatf("reset_slot%0d", i), expandedKey[128*i +: 128], 128'h0);
    rst = 1'b1;
    tick();
    check_flags("idle", 1'b0, 1'b0, 1'b0);

    // FIPS vector, single start pulse; key changes after acceptance are ignored.
    key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start = 1'b1;
    n_done = 0;
    tick();
    start = 1'b0;
    key   = 128'hdeadbeef_00000000_ffffffff_12345678;
    check("fips_slot0", expandedKey[127:0], 128'h3c4fcf098815f7aba6d2ae2816157e2b);
    check_flags("e0", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= NR; i++) begin
      tick();
      check($sformatf("fips_slot%0d", i), expandedKey[128*i +: 128], brev(fips_rk[i]));
      if (i < NR) check_flags($sformatf("e%0d", i), 1'b1, 1'b0, 1'b0);
    end
    check("fips_slot1_lit",  expandedKey[255:128],    128'h05766c2a3939a323b12c548817fefaa0);
    check("fips_slot10_lit", expandedKey[1407:1280],  128'ha60c63b6c80c3fe18925eec9a8f914d0);
    check_flags("e10", 1'b0, 1'b1, 1'b1);
    tick();
    check_flags("e11", 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    check("fips_done_count", 128'(n_done), 128'd1);

    // Start while busy at E5 with a different key: ignored.
    key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start = 1'b1;
    n_done = 0;
    tick();
    start = 1'b0;
    check_flags("sb_e0", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= NR; i++) begin
      if (i == 5) begin
        key   = 128'h000102030405060708090a0b0c0d0e0f;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check_flags("sb_e10", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= NR; i++) check($sformatf("sb_slot%0d", i), expandedKey[128*i +: 128], brev(fips_rk[i]));
    repeat (3) tick();
    check("sb_done_count", 128'(n_done), 128'd1);
    check_flags("sb_after", 1'b0, 1'b0, 1'b1);

    // Start held high: one restart exactly at E11.
    key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start = 1'b1;
    tick();
    check_flags("hold_e0", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < NR; i++) begin
      tick();
      check($sformatf("hold_busy_e%0d", i), 128'(busy), 128'd1);
    end
    tick();
    check_flags("hold_e10", 1'b0, 1'b1, 1'b1);
    check("hold_slot10", expandedKey[1407:1280], 128'ha60c63b6c80c3fe18925eec9a8f914d0);
    tick();
    start = 1'b0;
    check_flags("hold_e11", 1'b1, 1'b0, 1'b0);
    check("hold_slot10_kept", expandedKey[1407:1280], 128'ha60c63b6c80c3fe18925eec9a8f914d0);

    // Second run progressing; asynchronous reset after its E4.
    repeat (4) tick();
    check("rst_pre_busy", 128'(busy), 128'd1);
    #2;
    rst = 1'b0;
    #1;
    check_flags("rst_async", 1'b0, 1'b0, 1'b0);
    check("rst_slot0",  expandedKey[127:0],     128'h0);
    check("rst_slot4",  expandedKey[639:512],   128'h0);
    check("rst_slot10", expandedKey[1407:1280], 128'h0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check_flags("rst_idle", 1'b0, 1'b0, 1'b0);

    // Fresh run after reset with the 000102..0f key.
    key   = 128'h000102030405060708090a0b0c0d0e0f;
    start = 1'b1;
    n_done = 0;
    tick();
    start = 1'b0;
    check("k2_slot0", expandedKey[127:0], 128'h0f0e0d0c0b0a09080706050403020100);
    repeat (NR) tick();
    check_flags("k2_e10", 1'b0, 1'b1, 1'b1);
    check("k2_slot10", expandedKey[1407:1280], 128'hc5302b4d8ba707f3174a94e37f1d1113);
    check("k2_slot10_fips", brev(expandedKey[1407:1280]), 128'h13111d7fe3944a17f307a78b4d2b30c5);
    tick();
    check("k2_done_count", 128'(n_done), 128'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
